// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: FSM encoding and counter sizing.
package div_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring step: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] rem_sh;
  logic [WIDTH:0] trial;
  logic           non_neg;

  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    trial  = rem_sh - {1'b0, divisor};
    // A set shifted MSB means rem_sh >= 2^WIDTH > divisor, so the subtraction always
    // succeeds; otherwise the top bit of the difference is the borrow.
    non_neg = rem_sh[WIDTH] | ~trial[WIDTH];
    if (non_neg) begin
      rem_next = trial[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = rem_sh[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/restoring_div.sv
// Unsigned restoring divider: WIDTH+1 cycles per result (1 for divide by zero);
// one operation in flight, result held in DONE until out_ready.
module restoring_div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = clog2(WIDTH);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             dbz_q;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_q),
    .quo      (quo_q),
    .divisor  (dvs_q),
    .rem_next (rem_nx),
    .quo_next (quo_nx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      dbz_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            dvs_q <= divisor;
            cnt   <= CW'(WIDTH - 1);
            if (divisor == '0) begin
              quo_q <= '1;
              rem_q <= dividend;
              dbz_q <= 1'b1;
              state <= ST_DONE;
            end else begin
              // quo_q doubles as the dividend shift register during CALC
              quo_q <= dividend;
              rem_q <= '0;
              dbz_q <= 1'b0;
              state <= ST_CALC;
            end
          end
        end
        ST_CALC: begin
          quo_q <= quo_nx;
          rem_q <= rem_nx;
          if (cnt == '0) begin
            state <= ST_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == ST_IDLE);
  assign out_valid   = (state == ST_DONE);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule
